// File: rtl/log_stream_buffer_pkg.sv
// log_stream_buffer_pkg: shared state encoding and pointer arithmetic for the log stream buffer.
package log_stream_buffer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STORE   = 2'd1,
      DISCARD = 2'd2
   } state_e;

   // Distance a-b on a w-bit wrapping pointer; callers keep w <= 31.
   function automatic logic [31:0] ptr_dist(input logic [31:0] a, input logic [31:0] b, input int w);
      return (a - b) & ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/log_buffer_ram.sv
// log_buffer_ram: simple dual-port RAM, one write port and one registered read port, no reset.
module log_buffer_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/log_stream_buffer.sv
// log_stream_buffer: stores whole log-stream records in a circular RAM; records commit atomically on TLAST.
module log_stream_buffer
   import log_stream_buffer_pkg::*;
#(
   parameter int AXI_WIDTH        = 32,
   parameter int ADDR_WIDTH       = 10,
   parameter int MAX_PACKET_WORDS = 8,
   parameter int COUNT_WIDTH      = 16
) (
   input  logic                   sysClk,
   input  logic                   sysReset,
   input  logic [AXI_WIDTH-1:0]   sysLogTDATA,
   input  logic                   sysLogTVALID,
   input  logic                   sysLogTLAST,
   output logic                   sysLogTREADY,
   input  logic                   sysEnable,
   input  logic [ADDR_WIDTH-1:0]  sysReadAddr,
   output logic [AXI_WIDTH-1:0]   sysReadData,
   input  logic                   sysTailWrite,
   input  logic [ADDR_WIDTH:0]    sysTailValue,
   output logic [ADDR_WIDTH:0]    sysHead,
   output logic [ADDR_WIDTH:0]    sysTail,
   output logic                   sysNonEmpty,
   output logic [COUNT_WIDTH-1:0] sysDroppedCount,
   output logic [COUNT_WIDTH-1:0] sysOversizeCount
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam int BW = $clog2(MAX_PACKET_WORDS + 2);
   localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_WIDTH;
   localparam logic [BW-1:0] MAX_BEATS = BW'(MAX_PACKET_WORDS);

   state_e                 state_q;
   logic [PW-1:0]          head_q, tail_q, wr_ptr_q, used, free;
   logic [BW-1:0]          beat_cnt_q;
   logic [COUNT_WIDTH-1:0] dropped_q, oversize_q;
   logic                   tready_q, beat, has_room, tail_ok, ram_we;
   logic [ADDR_WIDTH-1:0]  ram_waddr;

   assign beat     = sysLogTVALID & tready_q;
   assign used     = PW'(ptr_dist(32'(head_q), 32'(tail_q), PW));
   assign free     = DEPTH - used;
   assign has_room = free >= PW'(MAX_PACKET_WORDS);
   // A new tail may only advance into data that has already been committed.
   assign tail_ok  = PW'(ptr_dist(32'(sysTailValue), 32'(tail_q), PW)) <= used;

   always_comb begin
      ram_we    = beat & (((state_q == IDLE) & sysEnable & has_room) |
                          ((state_q == STORE) & (beat_cnt_q < MAX_BEATS)));
      ram_waddr = (state_q == IDLE) ? head_q[ADDR_WIDTH-1:0] : wr_ptr_q[ADDR_WIDTH-1:0];
   end

   always_ff @(posedge sysClk) begin
      if (sysReset) begin
         state_q    <= IDLE;
         head_q     <= '0;
         tail_q     <= '0;
         wr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         dropped_q  <= '0;
         oversize_q <= '0;
         tready_q   <= 1'b0;
      end else begin
         tready_q <= 1'b1;
         if (sysTailWrite && tail_ok) tail_q <= sysTailValue;
         if (beat) begin
            unique case (state_q)
               IDLE: begin
                  if (sysEnable && has_room) begin
                     wr_ptr_q   <= head_q + PW'(1);
                     beat_cnt_q <= BW'(1);
                     if (sysLogTLAST) head_q <= head_q + PW'(1);
                     else state_q <= STORE;
                  end else begin
                     if (sysEnable) dropped_q <= dropped_q + COUNT_WIDTH'(dropped_q != '1);
                     if (!sysLogTLAST) state_q <= DISCARD;
                  end
               end
               STORE: begin
                  if (beat_cnt_q < MAX_BEATS) begin
                     wr_ptr_q   <= wr_ptr_q + PW'(1);
                     beat_cnt_q <= beat_cnt_q + BW'(1);
                     if (sysLogTLAST) begin
                        head_q  <= wr_ptr_q + PW'(1);
                        state_q <= IDLE;
                     end
                  end else begin
                     wr_ptr_q   <= head_q;
                     oversize_q <= oversize_q + COUNT_WIDTH'(oversize_q != '1);
                     state_q    <= sysLogTLAST ? IDLE : DISCARD;
                  end
               end
               DISCARD: if (sysLogTLAST) state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   log_buffer_ram #(
      .DATA_WIDTH(AXI_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk    (sysClk),
      .we_i   (ram_we),
      .waddr_i(ram_waddr),
      .wdata_i(sysLogTDATA),
      .raddr_i(sysReadAddr),
      .rdata_o(sysReadData)
   );

   assign sysLogTREADY     = tready_q;
   assign sysHead          = head_q;
   assign sysTail          = tail_q;
   assign sysNonEmpty      = head_q != tail_q;
   assign sysDroppedCount  = dropped_q;
   assign sysOversizeCount = oversize_q;

endmodule

// File: tb/tb_log_stream_buffer.sv
// tb_log_stream_buffer: directed checks of commit, drop, oversize, wrap and tail-write behaviour.
module tb_log_stream_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] tdata;
   logic        tvalid, tlast, tready, enable;
   logic [9:0]  raddr;
   logic [31:0] rdata;
   logic        tail_wr;
   logic [10:0] tail_val, head, tail;
   logic        non_empty;
   logic [15:0] dropped, oversize;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   log_stream_buffer dut (
      .sysClk          (clk),
      .sysReset        (rst),
      .sysLogTDATA     (tdata),
      .sysLogTVALID    (tvalid),
      .sysLogTLAST     (tlast),
      .sysLogTREADY    (tready),
      .sysEnable       (enable),
      .sysReadAddr     (raddr),
      .sysReadData     (rdata),
      .sysTailWrite    (tail_wr),
      .sysTailValue    (tail_val),
      .sysHead         (head),
      .sysTail         (tail),
      .sysNonEmpty     (non_empty),
      .sysDroppedCount (dropped),
      .sysOversizeCount(oversize)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tvalid = 1'b0;
      tlast = 1'b0;
      tail_wr = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic send(input logic [31:0] base, input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               tvalid = 1'b0;
               tdata = 32'hdeadbeef;
               tlast = 1'b1;
               tick();
            end
         end
         tvalid = 1'b1;
         tdata = base + 32'(i);
         tlast = (i == n - 1);
         tick();
      end
      tvalid = 1'b0;
      tlast = 1'b0;
   endtask

   task automatic rd(input logic [9:0] a, input logic [31:0] exp);
      raddr = a;
      tick();
      chk("read", rdata, exp);
   endtask

   task automatic wr_tail(input logic [10:0] v);
      tail_wr = 1'b1;
      tail_val = v;
      tick();
      tail_wr = 1'b0;
   endtask

   task automatic fill_and_wrap(input bit gaps);
      send(32'h100, 7, gaps);
      chk("t1_head", head, 11'd7);
      for (int i = 0; i < 7; i++) rd(10'(i), 32'h100 + 32'(i));
      for (int p = 1; p < 145; p++) send(32'h1000 + 32'(p * 16), 7, 1'b0);
      chk("t2_head145", head, 11'd1015);
      send(32'h200, 7, 1'b0);
      chk("t2_head146", head, 11'd1022);
      send(32'h280, 7, 1'b0);
      chk("t2_head147", head, 11'd1022);
      chk("t2_dropped", dropped, 16'd1);
      wr_tail(11'd7);
      chk("t3_tail", tail, 11'd7);
      send(32'h300, 7, gaps);
      chk("t3_head", head, 11'd1029);
      chk("t3_nonempty", non_empty, 1'b1);
      chk("t3_used", 11'(head - tail), 11'd1022);
      rd(10'd1022, 32'h300);
      rd(10'd1023, 32'h301);
      for (int i = 0; i < 5; i++) rd(10'(i), 32'h302 + 32'(i));
      rd(10'd1021, 32'h206);
   endtask

   initial begin
      enable = 1'b1;
      raddr = '0;
      tail_val = '0;
      tdata = '0;
      rst = 1'b1;
      tvalid = 1'b0;
      tlast = 1'b0;
      tail_wr = 1'b0;
      repeat (2) tick();
      chk("rst_tready", tready, 1'b0);
      chk("rst_head", head, 11'd0);
      rst = 1'b0;
      tick();
      chk("tready", tready, 1'b1);
      chk("rst_tail", tail, 11'd0);
      chk("rst_nonempty", non_empty, 1'b0);
      chk("rst_dropped", dropped, 16'd0);
      chk("rst_oversize", oversize, 16'd0);

      fill_and_wrap(1'b0);

      // Packets arriving while disabled are discarded without counting.
      enable = 1'b0;
      send(32'h380, 7, 1'b0);
      enable = 1'b1;
      chk("dis_head", head, 11'd1029);
      chk("dis_dropped", dropped, 16'd1);

      do_reset();
      send(32'h400, 10, 1'b0);
      chk("t4_oversize", oversize, 16'd1);
      chk("t4_head", head, 11'd0);
      send(32'h500, 7, 1'b0);
      chk("t4_head2", head, 11'd7);
      for (int i = 0; i < 7; i++) rd(10'(i), 32'h500 + 32'(i));

      wr_tail(11'd9);
      chk("t5_tail_rej", tail, 11'd0);
      wr_tail(11'd7);
      chk("t5_tail_ok", tail, 11'd7);
      chk("t5_nonempty", non_empty, 1'b0);

      send(32'h580, 3, 1'b0);
      do_reset();
      chk("t6_head", head, 11'd0);
      chk("t6_tail", tail, 11'd0);
      chk("t6_oversize", oversize, 16'd0);
      send(32'h600, 7, 1'b0);
      chk("t6_head2", head, 11'd7);
      for (int i = 0; i < 7; i++) rd(10'(i), 32'h600 + 32'(i));

      do_reset();
      fill_and_wrap(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
